// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: drives patterns into a gate network, compacts responses in a 10-bit MISR.
// Optional GATE_BIST_COUNTER_EN: binary-counter pattern source instead of the default LFSR.
module gate_bist_ctrl #(
    parameter int PAT_W      = 18,
    parameter int RESP_W     = 10,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  pat_count,
    input  logic [PAT_W-1:0]  seed,
    output logic [PAT_W-1:0]  pattern,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] signature,
    output logic [CNT_W-1:0]  pat_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [RESP_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        settle_q, settle_d;
    logic [CNT_W-1:0]  idx_inc;

    function automatic logic [PAT_W-1:0] next_pattern(input logic [PAT_W-1:0] p);
`ifdef GATE_BIST_COUNTER_EN
        return p + PAT_W'(1);
`else
        return {p[PAT_W-2:0], p[PAT_W-1] ^ p[10]};
`endif
    endfunction

    // The LFSR locks up at zero, so a zero seed is nudged to 1 in that mode.
    function automatic logic [PAT_W-1:0] load_pattern(input logic [PAT_W-1:0] s);
`ifdef GATE_BIST_COUNTER_EN
        return s;
`else
        return (s == '0) ? PAT_W'(1) : s;
`endif
    endfunction

    function automatic logic [RESP_W-1:0] misr_step(input logic [RESP_W-1:0] s,
                                                     input logic [RESP_W-1:0] r);
        logic [RESP_W-1:0] n;
        n    = {s[RESP_W-2:0], s[RESP_W-1]} ^ r;
        n[7] = n[7] ^ s[RESP_W-1];
        return n;
    endfunction

    assign idx_inc = idx_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        sig_d     = sig_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        settle_d  = settle_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pattern_d = load_pattern(seed);
                sig_d     = '0;
                idx_d     = '0;
                cnt_d     = pat_count;
                settle_d  = '0;
                state_d   = (pat_count == '0) ? S_DONE : S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = S_CAPTURE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            S_CAPTURE: begin
                sig_d = misr_step(sig_q, resp);
                idx_d = idx_inc;
                if (idx_inc == cnt_q) begin
                    state_d = S_DONE;
                end else begin
                    pattern_d = next_pattern(pattern_q);
                    state_d   = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pattern_q <= '0;
            sig_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            sig_q     <= sig_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            settle_q  <= settle_d;
        end
    end

    assign pattern   = pattern_q;
    assign signature = sig_q;
    assign pat_idx   = idx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl with default parameters (SETTLE_CYC=1).
// Expected patterns follow the LFSR, or the counter when GATE_BIST_COUNTER_EN is defined.
module tb_gate_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pat_count;
    logic [17:0] seed;
    logic [17:0] pattern;
    logic [9:0]  resp;
    logic        busy;
    logic        done;
    logic [9:0]  signature;
    logic [15:0] pat_idx;

    int errors = 0;
    int checks = 0;
    int lat;
    logic [17:0] pat_log [8];
    logic [9:0]  sig_log [8];

    always #5 clk = ~clk;

    gate_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pat_count (pat_count),
        .seed      (seed),
        .pattern   (pattern),
        .resp      (resp),
        .busy      (busy),
        .done      (done),
        .signature (signature),
        .pat_idx   (pat_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulses start and steps until done. With SETTLE_CYC=1, pattern j is visible
    // after step 1+2j and capture j lands after step 3+2j. lat is the step count
    // after which done is seen high (the edge sampling it is one later), -1 on timeout.
    task automatic run(input logic [17:0] sd, input logic [15:0] n, input logic [9:0] rv,
                       input logic hold_start, output int lt);
        for (int i = 0; i < 8; i++) begin
            pat_log[i] = 'x;
            sig_log[i] = 'x;
        end
        seed      = sd;
        pat_count = n;
        resp      = rv;
        start     = 1'b1;
        step();
        if (!hold_start) start = 1'b0;
        check("busy_in_load", {31'd0, busy}, 32'd1);
        lt = -1;
        for (int k = 1; k <= 200 && lt < 0; k++) begin
            step();
            if ((k % 2) == 1 && !done && ((k - 1) / 2) < 8) pat_log[(k - 1) / 2] = pattern;
            if ((k % 2) == 1 && k >= 3 && ((k - 3) / 2) < 8) sig_log[(k - 3) / 2] = signature;
            if (done) lt = k;
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b1;
        pat_count = 16'd0;
        seed      = 18'd0;
        resp      = 10'd0;

        // Reset held two cycles, with start high to show reset wins.
        step();
        step();
        check("rst_pattern",   32'(pattern),   32'h0);
        check("rst_signature", 32'(signature), 32'h0);
        check("rst_pat_idx",   32'(pat_idx),   32'h0);
        check("rst_busy",      {31'd0, busy},  32'd0);
        check("rst_done",      {31'd0, done},  32'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Empty run: done sampled by edge 2 after start.
        run(18'h00001, 16'd0, 10'h000, 1'b0, lat);
        check("empty_lat",       32'(lat),       32'd1);
        check("empty_signature", 32'(signature), 32'h000);
        check("empty_pat_idx",   32'(pat_idx),   32'h0);
        check("empty_busy_done", {31'd0, busy},  32'd1);
        step();
        check("empty_done_pulse", {31'd0, done}, 32'd0);
        check("empty_idle_busy",  {31'd0, busy}, 32'd0);

        // Three patterns, zero response: done sampled by edge 2+3*2=8.
        run(18'h00001, 16'd3, 10'h000, 1'b0, lat);
        check("lfsr_lat", 32'(lat), 32'd7);
        check("lfsr_p0",  32'(pat_log[0]), 32'h00001);
`ifdef GATE_BIST_COUNTER_EN
        check("lfsr_p1",  32'(pat_log[1]), 32'h00002);
        check("lfsr_p2",  32'(pat_log[2]), 32'h00003);
`else
        check("lfsr_p1",  32'(pat_log[1]), 32'h00002);
        check("lfsr_p2",  32'(pat_log[2]), 32'h00004);
`endif
        check("lfsr_signature", 32'(signature), 32'h000);
        check("lfsr_pat_idx",   32'(pat_idx),   32'd3);
        check("lfsr_pattern_at_done", 32'(pattern), 32'(pat_log[2]));
        step();

        // MISR with resp=0x001.
        run(18'h00001, 16'd2, 10'h001, 1'b0, lat);
        check("misr_lat",  32'(lat),        32'd5);
        check("misr_sig0", 32'(sig_log[0]), 32'h001);
        check("misr_sig1", 32'(signature),  32'h003);
        step();
        step();
        step();
        check("misr_hold", 32'(signature), 32'h003);

        // MISR feedback from bit 9 plus LFSR tap at bit 10.
        run(18'h00400, 16'd2, 10'h200, 1'b0, lat);
        check("fb_sig0", 32'(sig_log[0]), 32'h200);
        check("fb_sig1", 32'(signature),  32'h281);
        check("fb_p0",   32'(pat_log[0]), 32'h00400);
`ifdef GATE_BIST_COUNTER_EN
        check("fb_p1",   32'(pat_log[1]), 32'h00401);
`else
        check("fb_p1",   32'(pat_log[1]), 32'h00801);
`endif
        step();

        // Top-bit tap.
        run(18'h20000, 16'd2, 10'h000, 1'b0, lat);
`ifdef GATE_BIST_COUNTER_EN
        check("top_p1", 32'(pat_log[1]), 32'h20001);
`else
        check("top_p1", 32'(pat_log[1]), 32'h00001);
`endif
        step();

        // All-ones seed.
        run(18'h3FFFF, 16'd2, 10'h000, 1'b0, lat);
        check("ones_p0", 32'(pat_log[0]), 32'h3FFFF);
`ifdef GATE_BIST_COUNTER_EN
        check("ones_p1", 32'(pat_log[1]), 32'h00000);
`else
        check("ones_p1", 32'(pat_log[1]), 32'h3FFFE);
`endif
        step();

        // Zero seed.
        run(18'h00000, 16'd2, 10'h000, 1'b0, lat);
`ifdef GATE_BIST_COUNTER_EN
        check("zero_p0", 32'(pat_log[0]), 32'h00000);
        check("zero_p1", 32'(pat_log[1]), 32'h00001);
`else
        check("zero_p0", 32'(pat_log[0]), 32'h00001);
        check("zero_p1", 32'(pat_log[1]), 32'h00002);
`endif
        step();

        // Single-pattern run, all-ones response.
        run(18'h00005, 16'd1, 10'h3FF, 1'b0, lat);
        check("one_lat",       32'(lat),        32'd3);
        check("one_p0",        32'(pat_log[0]), 32'h00005);
        check("one_signature", 32'(signature),  32'h3FF);
        check("one_pat_idx",   32'(pat_idx),    32'd1);
        step();

        // Start held high: no restart mid-run, restart only from IDLE.
        run(18'h00001, 16'd2, 10'h000, 1'b1, lat);
        check("hold_lat", 32'(lat), 32'd5);
        step();
        check("hold_idle_busy", {31'd0, busy}, 32'd0);
        step();
        check("hold_restart_busy", {31'd0, busy}, 32'd1);
        step();
        check("hold_settle_pattern", 32'(pattern), 32'h00001);

        // Reset while in SETTLE, start still high.
        rst = 1'b1;
        step();
        check("abort_busy",      {31'd0, busy},  32'd0);
        check("abort_pattern",   32'(pattern),   32'h0);
        check("abort_done",      {31'd0, done},  32'd0);
        check("abort_pat_idx",   32'(pat_idx),   32'h0);
        check("abort_signature", 32'(signature), 32'h0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("abort_stays_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
